ax_arbiter: RTL and testbench
=============================

Name: ax_arbiter

Overview:
Two-master address-channel arbiter that drives the select (gnt) of an AxID/AxADDR/AxLEN/AxSIZE/AxBURST/AxVALID mux in front of one slave port.
- Picks between M0 and M1 round-robin.
- Holds the selection stable from grant through the address handshake.
- Optionally holds it through the associated data burst, counted in beats from AxLEN.
- Returns AxREADY to the granted master only.
- One instance per AR or AW channel in the interconnect.

Parameters:
HOLD_DATA, 1, 1 = keep grant until data burst completes; 0 = release after address handshake
LEN_BITS, `AXI_LEN_BITS (4), width of AxLEN and of the beat counter

Ports:
ACLK  in  1  clock
ARESETn  in  1  synchronous active-low reset
AxVALID_M0  in  1  address valid from master 0
AxVALID_M1  in  1  address valid from master 1
AxLEN  in  LEN_BITS  burst length from mux output (selected master)
AxREADY_S  in  1  address ready from slave
DVALID  in  1  data-beat valid on the channel tied to this grant (W or R)
DREADY  in  1  data-beat ready on that channel
DLAST  in  1  last-beat flag on that channel
gnt  out  1  mux select: 0 = M0, 1 = M1
AxREADY_M0  out  1  ready back to master 0
AxREADY_M1  out  1  ready back to master 1
busy  out  1  state != IDLE
data_phase  out  1  state == DATA; data mux uses gnt while high
len_err  out  1  one-cycle pulse on DLAST/counter mismatch

Behaviour:
- Single clock domain (ACLK). Reset is synchronous and active-low (ARESETn), sampled on ACLK rising edge.
- Reset values:
  - state = IDLE
  - gnt = 0, last_gnt = 1, so M0 wins the first tie
  - beat_cnt = 0
  - busy = 0, data_phase = 0, len_err = 0
  - AxREADY_M0 = AxREADY_M1 = 0
- Reset mid-transaction aborts to IDLE with the same values. No drain.
- States: IDLE, ADDR, DATA. gnt, last_gnt and beat_cnt are registered. AxREADY_Mx is combinational.
- IDLE:
  - Neither valid: stay.
  - One valid: gnt <= that master, go to ADDR.
  - Both valid: gnt <= ~last_gnt, go to ADDR.
  - Latency from AxVALID to usable grant is 1 cycle. There is one bubble cycle in IDLE between consecutive transactions.
- ADDR:
  - AxREADY_Mx = AxREADY_S & (gnt == x). The other master sees 0.
  - Handshake = (gnt ? AxVALID_M1 : AxVALID_M0) & AxREADY_S.
  - On handshake: last_gnt <= gnt; beat_cnt <= AxLEN. Go to DATA if HOLD_DATA, else IDLE.
  - No handshake: stay. gnt must not change. Dropping or raising the other master's valid has no effect.
  - If the granted valid drops without a handshake (AXI violation), stay in ADDR.
- DATA (HOLD_DATA = 1 only):
  - Beat = DVALID & DREADY.
  - On a beat with beat_cnt == 0: go to IDLE. If DLAST == 0, pulse len_err.
  - On a beat with beat_cnt != 0: beat_cnt decrements. If DLAST == 1, pulse len_err and stay.
  - The counter is authoritative; DLAST never terminates the burst.
  - AxREADY_M0/M1 = 0 throughout DATA.
  - AxLEN = 0 means a single beat. AxLEN = 2^LEN_BITS - 1 means 16 beats; the counter does not wrap.
- len_err is registered: asserted for exactly the cycle after the offending beat, otherwise 0.
- Simultaneous events:
  - A new request arriving in the cycle DATA ends is not granted until the IDLE cycle.
  - Address and first data beat may coincide (W before AW); such beats are not counted. The counter starts only in DATA.

Decomposition:
- Shared package axi_pkg:
  - LEN_BITS constant mirroring `AXI_LEN_BITS.
  - Enum arb_state_t {IDLE, ADDR, DATA}.
  - Master index type mst_idx_t (1 bit).
- Sub-module ax_rr_pick: combinational two-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: pick, any.
- Everything else lives inside ax_arbiter.

Test Plan:
1. Reset: ARESETn = 0 for 2 cycles with both valids high -> all outputs 0, gnt = 0. After release: gnt = 0, state ADDR on the next edge.
2. Round-robin: both valids held high, AxREADY_S = 1, HOLD_DATA = 0, AxLEN = 0 -> grants alternate 0,1,0,1. Each handshake is separated by one IDLE cycle.
3. Stall: M1 granted, AxREADY_S low for 5 cycles, M0 valid toggling -> gnt stays 1, AxREADY_M0 = 0 throughout. Handshake completes on the cycle AxREADY_S rises.
4. Burst hold: HOLD_DATA = 1, M0 AxLEN = 3, M1 requesting -> gnt stays 0 for exactly 4 beats (with DVALID/DREADY gaps inserted). M1 is granted 1 cycle after the 4th beat.
5. Length mismatch: AxLEN = 2, DLAST on beat 2 -> len_err pulses 1 cycle, burst still ends after beat 3. Then AxLEN = 1, no DLAST -> len_err pulses after beat 2.
6. Reset in DATA: ARESETn low during beat 2 of a 4-beat burst -> IDLE, busy = 0, beat_cnt = 0 next cycle. No len_err afterwards.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI address-channel types: burst-length width, arbiter state encoding, master index.
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif

package axi_pkg;

  localparam int LEN_BITS = `AXI_LEN_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef logic mst_idx_t;

endpackage

// File: rtl/ax_arbiter_if.sv
// Control bundle between the AR/AW arbiter and the mux, masters and slave around it.
interface ax_arbiter_if
  import axi_pkg::*;
#(
  parameter int LEN_BITS = axi_pkg::LEN_BITS
);

  logic                AxVALID_M0;
  logic                AxVALID_M1;
  logic [LEN_BITS-1:0] AxLEN;
  logic                AxREADY_S;
  logic                DVALID;
  logic                DREADY;
  logic                DLAST;
  mst_idx_t            gnt;
  logic                AxREADY_M0;
  logic                AxREADY_M1;
  logic                busy;
  logic                data_phase;
  logic                len_err;

  // slave = the arbiter itself; master = the surrounding fabric that feeds it
  modport slave (
    input  AxVALID_M0, AxVALID_M1, AxLEN, AxREADY_S, DVALID, DREADY, DLAST,
    output gnt, AxREADY_M0, AxREADY_M1, busy, data_phase, len_err
  );

  modport master (
    output AxVALID_M0, AxVALID_M1, AxLEN, AxREADY_S, DVALID, DREADY, DLAST,
    input  gnt, AxREADY_M0, AxREADY_M1, busy, data_phase, len_err
  );

endinterface

// File: rtl/ax_rr_pick.sv
// Two-way round-robin picker: on a tie the master that did not win last time is chosen.
module ax_rr_pick
  import axi_pkg::*;
(
  input  logic [1:0] req,
  input  mst_idx_t   last,
  output mst_idx_t   pick,
  output logic       any
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    any  = |req;
    pick = last;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = last;
    endcase
  end

endmodule

// File: rtl/ax_arbiter.sv
// AR/AW channel arbiter for two masters: round-robin grant, held through the address
// handshake and, when HOLD_DATA is set, through the AxLEN-counted data burst.
module ax_arbiter
  import axi_pkg::*;
#(
  parameter bit HOLD_DATA = 1'b1,
  parameter int LEN_BITS  = axi_pkg::LEN_BITS
)(
  input  logic         ACLK,
  input  logic         ARESETn,
  ax_arbiter_if.slave  bus
);

  arb_state_t          state;
  mst_idx_t            gntQ;
  mst_idx_t            lastGnt;
  logic [LEN_BITS-1:0] beatCnt;
  logic                lenErrQ;

  mst_idx_t            pick;
  logic                anyReq;

  ax_rr_pick u_pick (
    .req  ({bus.AxVALID_M1, bus.AxVALID_M0}),
    .last (lastGnt),
    .pick (pick),
    .any  (anyReq)
  );

  logic grantedValid;
  logic addrHs;
  logic dataBeat;

  assign grantedValid = gntQ ? bus.AxVALID_M1 : bus.AxVALID_M0;
  assign addrHs       = (state == ADDR) && grantedValid && bus.AxREADY_S;
  // Beats seen before DATA (W ahead of AW) are deliberately ignored.
  assign dataBeat     = (state == DATA) && bus.DVALID && bus.DREADY;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state   <= IDLE;
      gntQ    <= 1'b0;
      lastGnt <= 1'b1;
      beatCnt <= '0;
      lenErrQ <= 1'b0;
    end else begin
      lenErrQ <= 1'b0;
      case (state)
        IDLE: begin
          if (anyReq) begin
            gntQ  <= pick;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (addrHs) begin
            lastGnt <= gntQ;
            beatCnt <= bus.AxLEN;
            state   <= HOLD_DATA ? DATA : IDLE;
          end
        end
        DATA: begin
          // The counter ends the burst; DLAST is only cross-checked against it.
          if (dataBeat) begin
            if (beatCnt == '0) begin
              state   <= IDLE;
              lenErrQ <= ~bus.DLAST;
            end else begin
              beatCnt <= beatCnt - 1'b1;
              lenErrQ <= bus.DLAST;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gntQ;
  assign bus.AxREADY_M0 = (state == ADDR) && bus.AxREADY_S && (gntQ == 1'b0);
  assign bus.AxREADY_M1 = (state == ADDR) && bus.AxREADY_S && (gntQ == 1'b1);
  assign bus.busy       = (state != IDLE);
  assign bus.data_phase = (state == DATA);
  assign bus.len_err    = lenErrQ;

endmodule

// File: tb/tb_ax_arbiter.sv
// Bench for ax_arbiter: one instance without data hold (round-robin, stall) and one with
// data hold (bursts, length mismatch, reset mid-burst).
module tb_ax_arbiter;
  import axi_pkg::*;

  logic ACLK = 1'b0;
  logic ARESETn;
  int   nChecks = 0;
  int   nErrors = 0;

  mst_idx_t expQ[$];
  logic     monEn = 1'b0;

  typedef struct packed {
    logic v0, v1, rs;
    logic gnt, r0, r1, busy;
  } vec_t;
  vec_t tbl [8];

  ax_arbiter_if #(.LEN_BITS(LEN_BITS)) if0 ();
  ax_arbiter_if #(.LEN_BITS(LEN_BITS)) if1 ();

  ax_arbiter #(.HOLD_DATA(1'b0), .LEN_BITS(LEN_BITS)) u_dut0 (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (if0.slave)
  );

  ax_arbiter #(.HOLD_DATA(1'b1), .LEN_BITS(LEN_BITS)) u_dut1 (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (if1.slave)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv0(input logic v0, input logic v1, input logic rs);
    if0.AxVALID_M0 = v0;
    if0.AxVALID_M1 = v1;
    if0.AxREADY_S  = rs;
  endtask

  task automatic drv1(input logic v0, input logic v1, input logic rs,
                      input logic [LEN_BITS-1:0] len,
                      input logic dv, input logic dr, input logic dl);
    if1.AxVALID_M0 = v0;
    if1.AxVALID_M1 = v1;
    if1.AxREADY_S  = rs;
    if1.AxLEN      = len;
    if1.DVALID     = dv;
    if1.DREADY     = dr;
    if1.DLAST      = dl;
  endtask

  task automatic chk0(input string n, input logic g, input logic r0, input logic r1, input logic b);
    check({n, "_gnt"},  if0.gnt,        g);
    check({n, "_rdy0"}, if0.AxREADY_M0, r0);
    check({n, "_rdy1"}, if0.AxREADY_M1, r1);
    check({n, "_busy"}, if0.busy,       b);
    check({n, "_dp"},   if0.data_phase, 1'b0);
    check({n, "_lerr"}, if0.len_err,    1'b0);
  endtask

  task automatic chk1(input string n, input logic g, input logic r0, input logic r1,
                      input logic b, input logic dp, input logic le);
    check({n, "_gnt"},  if1.gnt,        g);
    check({n, "_rdy0"}, if1.AxREADY_M0, r0);
    check({n, "_rdy1"}, if1.AxREADY_M1, r1);
    check({n, "_busy"}, if1.busy,       b);
    check({n, "_dp"},   if1.data_phase, dp);
    check({n, "_lerr"}, if1.len_err,    le);
  endtask

  // Address handshakes on the non-holding instance are scored against the expected grant order.
  always @(negedge ACLK) begin
    mst_idx_t e;
    if (monEn && ARESETn &&
        ((if0.AxREADY_M0 && if0.AxVALID_M0) || (if0.AxREADY_M1 && if0.AxVALID_M1))) begin
      if (expQ.size() == 0) begin
        nChecks++;
        nErrors++;
        $display("FAIL hs_order: unexpected handshake, gnt=%b, expected none", if0.gnt);
      end else begin
        e = expQ.pop_front();
        check("hs_order", if0.gnt, e);
      end
    end
  end

  // One full transaction on the holding instance, starting from IDLE. Data beats are gapped;
  // DLAST is taken from mask per counted beat and driven high on non-beat cycles as noise.
  task automatic do_burst(input mst_idx_t mst, input logic [LEN_BITS-1:0] len,
                          input logic [15:0] mask, input logic otherReq);
    logic v0, v1, oth0, oth1, dv, dr, dl, beat, expErr;
    int   k, cyc;
    v0   = (mst == 1'b0) || otherReq;
    v1   = (mst == 1'b1) || otherReq;
    oth0 = (mst == 1'b1) && otherReq;
    oth1 = (mst == 1'b0) && otherReq;
    tick();
    drv1(v0, v1, 1'b1, len, 1'b0, 1'b0, 1'b0);
    settle();
    check("burst_idle_busy", if1.busy, 1'b0);
    tick();
    drv1(v0, v1, 1'b1, len, 1'b1, 1'b1, 1'b0);
    settle();
    chk1("burst_addr", mst, mst == 1'b0, mst == 1'b1, 1'b1, 1'b0, 1'b0);
    expErr = 1'b0;
    k      = 0;
    cyc    = 0;
    while (k <= int'(len)) begin
      tick();
      dv   = (cyc % 3) != 2;
      dr   = (cyc % 4) != 1;
      beat = dv && dr;
      dl   = beat ? mask[k] : 1'b1;
      drv1(oth0, oth1, 1'b1, ~len, dv, dr, dl);
      settle();
      chk1($sformatf("burst_data_k%0d_c%0d", k, cyc), mst, 1'b0, 1'b0, 1'b1, 1'b1, expErr);
      if (beat) begin
        expErr = (k == int'(len)) ? !dl : dl;
        k++;
      end else begin
        expErr = 1'b0;
      end
      cyc++;
    end
    tick();
    drv1(oth0, oth1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    settle();
    chk1("burst_end", mst, 1'b0, 1'b0, 1'b0, 1'b0, expErr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = 7'b111_0101;
    tbl[1] = 7'b111_0000;
    tbl[2] = 7'b111_1011;
    tbl[3] = 7'b111_1000;
    tbl[4] = 7'b111_0101;
    tbl[5] = 7'b111_0000;
    tbl[6] = 7'b111_1011;
    tbl[7] = 7'b001_1000;

    ARESETn    = 1'b0;
    drv0(1'b1, 1'b1, 1'b1);
    if0.AxLEN  = '0;
    if0.DVALID = 1'b0;
    if0.DREADY = 1'b0;
    if0.DLAST  = 1'b0;
    drv1(1'b1, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);

    // Reset held for two edges with both masters requesting.
    tick();
    tick();
    chk0("reset0", 1'b0, 1'b0, 1'b0, 1'b0);
    chk1("reset1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    ARESETn = 1'b1;
    drv1(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    expQ.push_back(1'b0);
    expQ.push_back(1'b1);
    expQ.push_back(1'b0);
    expQ.push_back(1'b1);
    monEn = 1'b1;

    // Round-robin with one IDLE bubble between handshakes.
    for (int i = 0; i < 8; i++) begin
      tick();
      drv0(tbl[i].v0, tbl[i].v1, tbl[i].rs);
      settle();
      chk0($sformatf("rr%0d", i), tbl[i].gnt, tbl[i].r0, tbl[i].r1, tbl[i].busy);
    end

    // Stall with M1 granted while M0 toggles its valid.
    tick();
    drv0(1'b0, 1'b1, 1'b0);
    settle();
    chk0("stall_idle", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      drv0(i[0], 1'b1, 1'b0);
      settle();
      chk0($sformatf("stall%0d", i), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    expQ.push_back(1'b1);
    tick();
    drv0(1'b1, 1'b1, 1'b1);
    settle();
    chk0("stall_release", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drv0(1'b0, 1'b0, 1'b0);
    settle();
    chk0("stall_done", 1'b1, 1'b0, 1'b0, 1'b0);
    check("sb_empty", expQ.size() == 0, 1'b1);

    // Burst hold: M0 with AxLEN=3 while M1 keeps requesting; M1 follows after the IDLE bubble.
    do_burst(1'b0, 4'd3, 16'h0008, 1'b1);
    tick();
    drv1(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    settle();
    chk1("hold_m1_grant", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drv1(1'b0, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    settle();
    chk1("hold_m1_addr", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drv1(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    settle();
    chk1("hold_m1_data", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drv1(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    settle();
    chk1("hold_m1_done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Length mismatches, single-beat and maximum-length bursts.
    do_burst(1'b1, 4'd2,  16'b0110, 1'b0);
    do_burst(1'b0, 4'd1,  16'b0000, 1'b0);
    do_burst(1'b0, 4'd0,  16'h0001, 1'b0);
    do_burst(1'b1, 4'd15, 16'h8000, 1'b0);

    // Reset on the second beat of a four-beat burst (DLAST set there to provoke an error).
    tick();
    drv1(1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    settle();
    tick();
    drv1(1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    settle();
    chk1("rst_addr", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drv1(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    settle();
    chk1("rst_beat1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drv1(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    ARESETn = 1'b0;
    settle();
    chk1("rst_beat2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    ARESETn = 1'b1;
    drv1(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    settle();
    chk1("rst_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    settle();
    chk1("rst_after2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_burst(1'b0, 4'd0, 16'h0001, 1'b0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
